// File: rtl/queued_instr_decoder_if.sv
// Opcode delivery channel: valid/ready handshake from the instruction source into the decoder.
interface queued_instr_decoder_if #(
  parameter int OP_W = 4
);
  logic [OP_W-1:0] instr;
  logic            instr_valid;
  logic            instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/queued_instr_decoder.sv
// Buffered MiniCPU decoder: a small opcode FIFO feeding an issue FSM that emits one
// registered strobe set per opcode, stretches CLEAR and counts illegal opcodes.
module queued_instr_decoder #(
  parameter int OP_W       = 4,
  parameter int SEL_W      = 3,
  parameter int DEPTH      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int ERR_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  queued_instr_decoder_if.slave  bus,
  output logic                   CLR,
  output logic                   EN_A,
  output logic                   EN_B,
  output logic                   EN_OUT,
  output logic                   SRC_SEL,
  output logic [SEL_W-1:0]       ALU_SEL,
  output logic                   illegal,
  output logic [ERR_W-1:0]       err_count,
  output logic                   busy
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int CLR_W    = $clog2(CLR_CYCLES + 1);
  localparam int ALU_LAST = 3 + 2**SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state_r;
  logic [OP_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              ready_r;
  logic [CLR_W-1:0]  clr_left_r;
  logic              stall_s;
  logic              push_s;
  logic              pop_s;
  logic [OP_W-1:0]   head_s;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (int'(op) >= 32'sd4) && (int'(op) <= ALU_LAST);
  endfunction

  assign bus.instr_ready = ready_r;
  assign busy            = (count_r != {CNT_W{1'b0}}) || (state_r != IDLE);

  // Handshake qualification and next FIFO occupancy; pops are held off while CLEAR is stretched.
  always_comb begin
    stall_s = (state_r == CLEAR) && (clr_left_r != {CLR_W{1'b0}});
    push_s  = bus.instr_valid & ready_r;
    pop_s   = (count_r != {CNT_W{1'b0}}) & ~stall_s;
    head_s  = mem_r[rd_ptr_r];
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Opcode storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.instr;
    end
  end

  // Pointers, occupancy and ready, which is derived from the post-edge count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != CNT_W'(DEPTH));
    end
  end

  // Issue FSM with registered strobes; during a CLEAR stall the strobes simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      clr_left_r <= {CLR_W{1'b0}};
      CLR        <= 1'b0;
      EN_A       <= 1'b0;
      EN_B       <= 1'b0;
      EN_OUT     <= 1'b0;
      SRC_SEL    <= 1'b0;
      ALU_SEL    <= {SEL_W{1'b0}};
      illegal    <= 1'b0;
      err_count  <= {ERR_W{1'b0}};
    end else begin
      illegal <= 1'b0;
      if (stall_s) begin
        clr_left_r <= clr_left_r - CLR_W'(1);
      end else if (pop_s) begin
        state_r                    <= ISSUE;
        {CLR, EN_A, EN_B, EN_OUT}  <= 4'b0000;
        case (head_s)
          OP_W'(0): begin
            {CLR, EN_A, EN_B, EN_OUT} <= 4'b1111;
            state_r                   <= CLEAR;
            clr_left_r                <= CLR_W'(CLR_CYCLES - 1);
          end
          OP_W'(1): EN_A <= 1'b1;
          OP_W'(2): begin
            EN_B    <= 1'b1;
            SRC_SEL <= 1'b0;
          end
          OP_W'(3): begin
            EN_B    <= 1'b1;
            SRC_SEL <= 1'b1;
          end
          default: begin
            if (is_alu(head_s)) begin
              EN_OUT  <= 1'b1;
              ALU_SEL <= SEL_W'(head_s - OP_W'(4));
            end else begin
              illegal <= 1'b1;
              if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
              end
            end
          end
        endcase
      end else begin
        state_r                   <= IDLE;
        {CLR, EN_A, EN_B, EN_OUT} <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_queued_instr_decoder.sv
// Bench for queued_instr_decoder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_queued_instr_decoder;
  localparam int OP_W       = 4;
  localparam int SEL_W      = 3;
  localparam int DEPTH      = 4;
  localparam int CLR_CYCLES = 2;
  localparam int ERR_W      = 3;
  localparam int ERR_MAX    = 2**ERR_W - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic CLR, EN_A, EN_B, EN_OUT, SRC_SEL, illegal, busy;
  logic [SEL_W-1:0] ALU_SEL;
  logic [ERR_W-1:0] err_count;

  queued_instr_decoder_if #(.OP_W(OP_W)) bus ();

  queued_instr_decoder #(
    .OP_W(OP_W), .SEL_W(SEL_W), .DEPTH(DEPTH), .CLR_CYCLES(CLR_CYCLES), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .CLR(CLR), .EN_A(EN_A), .EN_B(EN_B), .EN_OUT(EN_OUT), .SRC_SEL(SRC_SEL),
    .ALU_SEL(ALU_SEL), .illegal(illegal), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain opcode queue plus the decode table, stepped once per clock edge.
  int q[$];
  int m_stall = 0, m_err = 0, m_alu = 0, n_acc = 0;
  bit m_clr = 0, m_a = 0, m_b = 0, m_out = 0, m_src = 0, m_ill = 0, m_ready = 0, m_busy = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_stall = 0; m_err = 0; m_alu = 0; m_src = 0; m_ill = 0;
      m_clr = 0; m_a = 0; m_b = 0; m_out = 0; m_ready = 0; m_busy = 0;
    end else begin
      bit act;
      int op;
      act   = 0;
      m_ill = 0;
      if (m_stall > 0) begin
        m_stall--;
        act = 1;
      end else begin
        m_clr = 0; m_a = 0; m_b = 0; m_out = 0;
        if (q.size() > 0) begin
          op  = q.pop_front();
          act = 1;
          if (op == 0) begin
            m_clr = 1; m_a = 1; m_b = 1; m_out = 1;
            m_stall = CLR_CYCLES - 1;
          end else if (op == 1) m_a = 1;
          else if (op == 2) begin m_b = 1; m_src = 0; end
          else if (op == 3) begin m_b = 1; m_src = 1; end
          else if (op >= 4 && op <= 3 + 2**SEL_W) begin m_out = 1; m_alu = op - 4; end
          else begin
            m_ill = 1;
            if (m_err < ERR_MAX) m_err++;
          end
        end
      end
      if (bus.instr_valid && m_ready) begin
        q.push_back(int'(bus.instr));
        n_acc++;
      end
      m_ready = (q.size() < DEPTH);
      m_busy  = act || (q.size() > 0);
    end
  end

  always @(negedge clk) begin
    chk("ready",   bus.instr_ready, m_ready);
    chk("CLR",     CLR,     m_clr);
    chk("EN_A",    EN_A,    m_a);
    chk("EN_B",    EN_B,    m_b);
    chk("EN_OUT",  EN_OUT,  m_out);
    chk("SRC_SEL", SRC_SEL, m_src);
    chk("ALU_SEL", ALU_SEL, m_alu);
    chk("illegal", illegal, m_ill);
    chk("err",     err_count, m_err);
    chk("busy",    busy,    m_busy);
  end

  task automatic push_list(input int ops[$]);
    foreach (ops[i]) begin
      bus.instr       = OP_W'(ops[i]);
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk("drain_bound", (n < 50), 1);
  endtask

  initial begin
    int acc0, clr_cnt, n;
    bit saw_full;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rel_ready_low", bus.instr_ready, 0);
    step();
    chk("rel_ready_high", bus.instr_ready, 1);
    chk("rel_busy", busy, 0);

    // MOVE1 then ALU op 0
    push_list('{1, 4});
    chk("t2_en_a", {CLR, EN_A, EN_B, EN_OUT}, 4'b0100);
    step();
    chk("t2_en_out", {CLR, EN_A, EN_B, EN_OUT}, 4'b0001);
    chk("t2_alu", ALU_SEL, 0);
    drain();

    // CLEAR stretched over two cycles, then ALU op 5
    push_list('{0, 9});
    chk("t3_clr_c1", {CLR, EN_A, EN_B, EN_OUT}, 4'b1111);
    step();
    chk("t3_clr_c2", {CLR, EN_A, EN_B, EN_OUT}, 4'b1111);
    step();
    chk("t3_alu_op", {CLR, EN_A, EN_B, EN_OUT}, 4'b0001);
    chk("t3_alu_sel", ALU_SEL, 5);
    drain();

    // MOVE2, STORE, ALU op 7 with SRC_SEL retained
    push_list('{2, 3, 11});
    chk("t4_store", {EN_B, SRC_SEL}, 2'b11);
    step();
    chk("t4_alu7", {EN_OUT, EN_B}, 2'b10);
    chk("t4_alu_sel", ALU_SEL, 7);
    chk("t4_src_hold", SRC_SEL, 1);
    drain();

    // Illegal opcodes and counter saturation
    push_list('{12, 13, 14, 15});
    chk("t5_pulse", {illegal, EN_OUT}, 2'b10);
    drain();
    chk("t5_err4", err_count, 4);
    push_list('{12, 12, 12, 12, 12});
    drain();
    chk("t5_sat", err_count, ERR_MAX);

    // Back-pressure: hold CLEAR valid until the FIFO fills
    acc0 = n_acc; clr_cnt = 0; saw_full = 0;
    bus.instr = '0; bus.instr_valid = 1'b1;
    repeat (12) begin
      step();
      if (!bus.instr_ready) saw_full = 1;
      if (CLR) clr_cnt++;
    end
    bus.instr_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      step();
      if (CLR) clr_cnt++;
      n++;
    end
    chk("t6_bound", (n < 50), 1);
    chk("t6_full_seen", saw_full, 1);
    chk("t6_accepted", n_acc - acc0, 9);
    chk("t6_clr_cycles", clr_cnt, 18);
    chk("t6_no_loss", clr_cnt, (n_acc - acc0) * CLR_CYCLES);

    // Reset mid-CLEAR with opcodes still queued
    push_list('{0, 4, 1});
    #2 rst = 1'b1;
    #1;
    chk("t1_async_strobes", {CLR, EN_A, EN_B, EN_OUT}, 4'b0000);
    chk("t1_async_ready", bus.instr_ready, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_err", err_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    step();
    chk("t1_ready_after", bus.instr_ready, 1);
    chk("t1_busy_after", busy, 0);
    repeat (3) begin
      step();
      chk("t1_discarded", {CLR, EN_A, EN_B, EN_OUT}, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
